// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences one ALU operation over the shared bus datapath.
//   Ra -> Y (LOAD_Y), Rb on bus with ALU strobe and Zin (EXEC), Z -> Rz (WB_LO),
//   optional Z[63:32] -> HI (WB_HI), then a one-cycle done pulse (DONE).
// Optional feature macro: ALU_SEQ_HILO_EN (MUL/DIV write LO/HI instead of Rz).
// Ports:
//   clock, clear        rising-edge clock, synchronous active-low reset
//   start, opcode       request pulse and op code (captured only in IDLE)
//   ra_sel/rb_sel/rz_sel source Y, source bus in EXEC, destination register
//   busy, done, illegal status; illegal is valid with done
//   reg_out_sel, Rout   register-file bus drive
//   Yin, Zin            Y / Z loads
//   Zlowout, Zhighout   Z halves onto the bus
//   Rin, rin_sel        register-file write
//   LOin, HIin          LO / HI loads
//   alu_op, ADD, IncPC, AND, OR, BRANCH  ALU op select (EXEC only)
// All outputs are registered: next-cycle outputs are decoded from the next state.
module alu_op_sequencer #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned OP_W          = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            start,
  input  logic [OP_W-1:0] opcode,
  input  logic [3:0]      ra_sel,
  input  logic [3:0]      rb_sel,
  input  logic [3:0]      rz_sel,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic [3:0]      reg_out_sel,
  output logic            Rout,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            Rin,
  output logic [3:0]      rin_sel,
  output logic            LOin,
  output logic            HIin,
  output logic [OP_W-1:0] alu_op,
  output logic            ADD,
  output logic            IncPC,
  output logic            AND,
  output logic            OR,
  output logic            BRANCH
);

  localparam int unsigned CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  localparam logic [OP_W-1:0] OP_AND    = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_OR     = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_ADD    = OP_W'(4'b0100);
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(4'b0111);
  localparam logic [OP_W-1:0] OP_INCPC  = OP_W'(4'b1101);
  localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(4'b1110);
  localparam logic [OP_W-1:0] OP_ILL    = OP_W'(4'b1111);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_EXEC,
    S_WB_LO,
    S_WB_HI,
    S_DONE
  } state_t;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            illegal;
    logic [3:0]      reg_out_sel;
    logic            rout;
    logic            yin;
    logic            zin;
    logic            zlowout;
    logic            zhighout;
    logic            rin;
    logic [3:0]      rin_sel;
    logic            lo_in;
    logic            hi_in;
    logic [OP_W-1:0] alu_op;
    logic            add;
    logic            inc_pc;
    logic            and_s;
    logic            or_s;
    logic            branch;
  } ctl_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [3:0]       ra_q, ra_d, rb_q, rb_d, rz_q, rz_d;
  ctl_t             ctl_q, ctl_d;
  logic             muldiv_q, muldiv_d;

  assign muldiv_q = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign muldiv_d = (op_d == OP_MUL) || (op_d == OP_DIV);

  // Next state, operand capture, and the output set for the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rz_d    = rz_q;
    ctl_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = opcode;
          ra_d    = ra_sel;
          rb_d    = rb_sel;
          rz_d    = rz_sel;
          state_d = S_LOAD_Y;
        end
      end
      S_LOAD_Y: begin
        if (op_q == OP_ILL) begin
          state_d = S_DONE;
        end else begin
          state_d = S_EXEC;
          cnt_d   = muldiv_q ? CNT_W'(MULDIV_CYCLES - 1) : '0;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_WB_LO;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WB_LO: begin
`ifdef ALU_SEQ_HILO_EN
        state_d = muldiv_q ? S_WB_HI : S_DONE;
`else
        state_d = S_DONE;
`endif
      end
      S_WB_HI: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ctl_d.busy = (state_d != S_IDLE);

    case (state_d)
      S_LOAD_Y: begin
        // An illegal op passes through LOAD_Y with nothing but busy.
        if (op_d != OP_ILL) begin
          ctl_d.rout        = 1'b1;
          ctl_d.reg_out_sel = ra_d;
          ctl_d.yin         = 1'b1;
        end
      end
      S_EXEC: begin
        ctl_d.rout        = 1'b1;
        ctl_d.reg_out_sel = rb_d;
        ctl_d.alu_op      = op_d;
        ctl_d.zin         = (cnt_d == '0);
        ctl_d.add         = (op_d == OP_ADD);
        ctl_d.inc_pc      = (op_d == OP_INCPC);
        ctl_d.and_s       = (op_d == OP_AND);
        ctl_d.or_s        = (op_d == OP_OR);
        ctl_d.branch      = (op_d == OP_BRANCH);
      end
      S_WB_LO: begin
        ctl_d.zlowout = 1'b1;
`ifdef ALU_SEQ_HILO_EN
        if (muldiv_d) begin
          ctl_d.lo_in = 1'b1;
        end else begin
          ctl_d.rin     = 1'b1;
          ctl_d.rin_sel = rz_d;
        end
`else
        ctl_d.rin     = 1'b1;
        ctl_d.rin_sel = rz_d;
`endif
      end
      S_WB_HI: begin
`ifdef ALU_SEQ_HILO_EN
        ctl_d.zhighout = 1'b1;
        ctl_d.hi_in    = 1'b1;
`endif
      end
      S_DONE: begin
        ctl_d.done    = 1'b1;
        ctl_d.illegal = (op_d == OP_ILL);
      end
      default: ;
    endcase
  end

  // State, operand and output registers; clear abandons any in-flight op.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rz_q    <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rz_q    <= rz_d;
      ctl_q   <= ctl_d;
    end
  end

  assign busy        = ctl_q.busy;
  assign done        = ctl_q.done;
  assign illegal     = ctl_q.illegal;
  assign reg_out_sel = ctl_q.reg_out_sel;
  assign Rout        = ctl_q.rout;
  assign Yin         = ctl_q.yin;
  assign Zin         = ctl_q.zin;
  assign Zlowout     = ctl_q.zlowout;
  assign Rin         = ctl_q.rin;
  assign rin_sel     = ctl_q.rin_sel;
  assign alu_op      = ctl_q.alu_op;
  assign ADD         = ctl_q.add;
  assign IncPC       = ctl_q.inc_pc;
  assign AND         = ctl_q.and_s;
  assign OR          = ctl_q.or_s;
  assign BRANCH      = ctl_q.branch;

`ifdef ALU_SEQ_HILO_EN
  assign Zhighout = ctl_q.zhighout;
  assign LOin     = ctl_q.lo_in;
  assign HIin     = ctl_q.hi_in;
`else
  // Without the HI/LO feature these outputs are constant zero.
  assign Zhighout = 1'b0;
  assign LOin     = 1'b0;
  assign HIin     = 1'b0;
  logic unused_hilo;
  assign unused_hilo = ^{ctl_q.zhighout, ctl_q.lo_in, ctl_q.hi_in};
`endif

endmodule
